// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity types, legal oversampling ratios
// and small helpers used by the receiver datapath.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Any ratio other than 16 or 32 falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            PRESCALE_16: r = PRESCALE_16;
            PRESCALE_32: r = PRESCALE_32;
            default:     r = PRESCALE_8;
        endcase
        return r;
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three mid-bit samples and a 2-of-3 vote.
// edge_cnt always equals the index of the current clock edge within the bit.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       active_i,
    input  logic [5:0] prescale_i,
    input  logic       rx_i,
    output logic       sampled_bit_o,
    output logic       bit_done_o,
    output logic       sample_valid_o
);

    logic [5:0] edge_cnt_q;
    logic [5:0] edge_cnt_d;
    logic [2:0] smp_q;
    logic [2:0] smp_d;
    logic [5:0] half_s;
    logic [5:0] last_s;

    assign half_s = {1'b0, prescale_i[5:1]};
    assign last_s = prescale_i - 6'd1;

    // Next edge count and sample capture.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        smp_d      = smp_q;
        if (start_i) begin
            // The detect edge itself was edge 0 of the start bit.
            edge_cnt_d = 6'd1;
        end else if (active_i) begin
            if (edge_cnt_q == last_s) begin
                edge_cnt_d = 6'd0;
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end
        end else begin
            edge_cnt_d = 6'd0;
        end

        if (active_i) begin
            if (edge_cnt_q == half_s - 6'd1) begin
                smp_d[0] = rx_i;
            end else if (edge_cnt_q == half_s) begin
                smp_d[1] = rx_i;
            end else if (edge_cnt_q == half_s + 6'd1) begin
                smp_d[2] = rx_i;
            end else begin
                smp_d = smp_q;
            end
        end else begin
            smp_d = smp_q;
        end
    end

    // Counter and sample registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_q <= 6'd0;
            smp_q      <= 3'b000;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            smp_q      <= smp_d;
        end
    end

    assign sampled_bit_o  = maj3(smp_q);
    assign bit_done_o     = active_i && (edge_cnt_q == last_s);
    assign sample_valid_o = active_i && (edge_cnt_q >= half_s + 6'd2);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity and stop checks.
// Configuration is captured at each frame start so mid-frame changes are ignored.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    logic [2:0]            state_q,   state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic                  par_err_q, par_err_d;
    logic [5:0]            p_q,       p_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] p_data_q,  p_data_d;
    logic                  dv_q,      dv_d;
    logic                  pe_q,      pe_d;
    logic                  se_q,      se_d;

    logic frame_start_s;
    logic sampled_bit_s;
    logic bit_done_s;
    logic sample_valid_s;
    logic bit_end_s;
    logic exp_par_s;
    logic stp_bad_s;

    uart_rx_sampler u_sampler (
        .clk_i          (CLK),
        .rst_i          (RST),
        .start_i        (frame_start_s),
        .active_i       (state_q != S_IDLE),
        .prescale_i     (p_q),
        .rx_i           (RX_IN),
        .sampled_bit_o  (sampled_bit_s),
        .bit_done_o     (bit_done_s),
        .sample_valid_o (sample_valid_s)
    );

    assign bit_end_s = bit_done_s & sample_valid_s;
    assign exp_par_s = (^shift_q) ^ (par_typ_q == PAR_ODD);
    assign stp_bad_s = ~sampled_bit_s;

    // Frame sequencing, deserializing and error evaluation.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        p_d           = p_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        p_data_d      = p_data_q;
        dv_d          = 1'b0;
        pe_d          = 1'b0;
        se_d          = 1'b0;
        frame_start_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    frame_start_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = sampled_bit_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    shift_d = {sampled_bit_s, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = {CW{1'b0}};
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    par_err_d = (sampled_bit_s != exp_par_s);
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    pe_d = par_err_q;
                    se_d = stp_bad_s;
                    if (!par_err_q && !stp_bad_s) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end else begin
                        p_data_d = p_data_q;
                    end
                    // A low line on the final stop edge is already the next start bit.
                    if (!RX_IN) begin
                        frame_start_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_start_s) begin
            state_d   = S_START;
            bit_cnt_d = {CW{1'b0}};
            par_err_d = 1'b0;
            p_d       = legal_prescale(PRESCALE);
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
        end else begin
            par_typ_d = par_typ_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= {CW{1'b0}};
            shift_q   <= {DATA_WIDTH{1'b0}};
            par_err_q <= 1'b0;
            p_q       <= PRESCALE_8;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            p_data_q  <= {DATA_WIDTH{1'b0}};
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            p_q       <= p_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, parity/stop errors, start glitch,
// back-to-back frames and mid-frame reset.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;
    int dv_cyc[$];
    int dv0, pe0, se0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc.push_back(cyc);
        end
        if (PAR_ERR) pe_cnt = pe_cnt + 1;
        if (STP_ERR) se_cnt = se_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic snap();
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        se0 = se_cnt;
    endtask

    // Drives a whole frame; returns #1 after the final stop-bit edge (detect edge + N*P-1).
    task automatic send_frame(input logic [7:0] d, input int p, input bit has_par,
                              input bit par_bit, input bit stop_bit, input bit scramble);
        RX_IN = 1'b0;
        tick(p);
        if (scramble) begin
            PRESCALE = 6'd32;
            PAR_EN   = 1'b1;
            PAR_TYP  = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            tick(p);
        end
        if (has_par) begin
            RX_IN = par_bit;
            tick(p);
        end
        RX_IN = stop_bit;
        tick(p);
    endtask

    // Checks outputs at the frame-end cycle, then one cycle later checks pulse width and counts.
    task automatic expect_frame(input string tag, input bit dv, input bit pe, input bit se,
                                input logic [7:0] pd);
        check_val({tag, "_dv"},    {31'd0, DATA_VALID}, {31'd0, dv});
        check_val({tag, "_pe"},    {31'd0, PAR_ERR},    {31'd0, pe});
        check_val({tag, "_se"},    {31'd0, STP_ERR},    {31'd0, se});
        check_val({tag, "_pdata"}, {24'd0, P_DATA},     {24'd0, pd});
        tick(1);
        check_val({tag, "_pulse"}, {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
        check_val({tag, "_ndv"}, dv_cnt - dv0, {31'd0, dv});
        check_val({tag, "_npe"}, pe_cnt - pe0, {31'd0, pe});
        check_val({tag, "_nse"}, se_cnt - se0, {31'd0, se});
    endtask

    initial begin
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        tick(3);
        check_val("rst_out", {21'd0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);

        // Detect on the very first edge after reset release; DATA_VALID 79 cycles later.
        RST = 1'b0;
        snap();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_frame("a5_p8", 1'b1, 1'b0, 1'b0, 8'hA5);
        tick(5);

        // Even parity, 0x3C has four ones so parity 1 is wrong; error at 175.
        PRESCALE = 6'd16;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_frame("3c_even", 1'b0, 1'b1, 1'b0, 8'hA5);
        tick(5);

        // Odd parity with the same bit is correct.
        PAR_TYP = 1'b1;
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_frame("3c_odd", 1'b1, 1'b0, 1'b0, 8'h3C);
        tick(5);

        // Stop bit 0.
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        snap();
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_frame("0f_stop", 1'b0, 1'b0, 1'b1, 8'h3C);
        snap();
        RX_IN = 1'b1;
        tick(20);
        check_val("stop_tail_pulses", dv_cnt + pe_cnt + se_cnt - dv0 - pe0 - se0, 32'd0);

        // Start glitch: low for 3 edges, then the receiver must be idle again by edge 8.
        snap();
        RX_IN = 1'b0;
        tick(3);
        RX_IN = 1'b1;
        tick(5);
        check_val("glitch_pulses", dv_cnt + pe_cnt + se_cnt - dv0 - pe0 - se0, 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_frame("after_glitch", 1'b1, 1'b0, 1'b0, 8'h5A);
        tick(5);

        // Illegal ratio 12 acts as 8; config changes after the start bit are ignored.
        PRESCALE = 6'd12;
        snap();
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame("illegal_p", 1'b1, 1'b0, 1'b0, 8'h33);
        tick(5);

        // Back-to-back frames at P=32.
        PRESCALE = 6'd32;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        snap();
        dv_cyc.delete();
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("b2b_dv1", {31'd0, DATA_VALID}, 32'd1);
        check_val("b2b_pd1", {24'd0, P_DATA}, 32'h55);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("b2b_dv2", {31'd0, DATA_VALID}, 32'd1);
        check_val("b2b_pd2", {24'd0, P_DATA}, 32'hAA);
        tick(1);
        check_val("b2b_ndv", dv_cnt - dv0, 32'd2);
        if (dv_cyc.size() == 2) begin
            check_val("b2b_gap", dv_cyc[1] - dv_cyc[0], 32'd320);
        end else begin
            check_val("b2b_cnt", dv_cyc.size(), 32'd2);
        end
        tick(5);

        // Reset in the middle of data bit 3, then a clean frame.
        PRESCALE = 6'd16;
        RX_IN = 1'b0;
        tick(16);
        RX_IN = 1'b1;
        tick(16);
        RX_IN = 1'b0;
        tick(32);
        RX_IN = 1'b1;
        tick(5);
        RST = 1'b1;
        tick(1);
        check_val("midrst_out", {21'd0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
        RST = 1'b0;
        tick(3);
        snap();
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_frame("after_rst", 1'b1, 1'b0, 1'b0, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
